// File: rtl/bram_stream_loader_if.sv
// Stream-in / BRAM-write bundle for bram_stream_loader.
// Latency: wires only; timing is set by the modules on each side.
// Backpressure: the s_valid/s_ready handshake; the BRAM side is a plain write port with no backpressure.
//
// Signals:
//   s_valid, s_data  stream byte, driven by the stream source
//   s_ready          driven by the loader
//   addr, ce, we, d  BRAM write port, driven by the loader
//
// Modports:
//   slave   loader view: sinks the stream and drives the BRAM port
//   master  environment view: sources the stream and observes the BRAM port
interface bram_stream_loader_if #(
    parameter int AWIDTH        = 12,
    parameter int DWIDTH        = 32,
    parameter int IN_DATA_WIDTH = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic [IN_DATA_WIDTH-1:0] s_data;
    logic [AWIDTH-1:0]        addr;
    logic                     ce;
    logic                     we;
    logic [DWIDTH-1:0]        d;

    modport slave (
        input  s_valid, s_data,
        output s_ready, addr, ce, we, d
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, addr, ce, we, d
    );
endinterface

// File: rtl/bram_stream_loader.sv
// Fills one dual-port BRAM bank from a byte stream: packs 4 bytes per word, first byte in MSBs, addresses 0 upward.
// Latency: write strobe 1 cycle after a word's 4th byte; o_done 2 cycles and IDLE 3 cycles after the last byte.
// Backpressure: s_ready is high only in RUN while words remain; s_valid gaps of any length are tolerated.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   i_run           start pulse, sampled only in IDLE
//   i_num_cnt       words to load, clamped to MEM_SIZE and captured on an accepted i_run
//   o_idle/o_write/o_done  state flags: IDLE, RUN, one-cycle DONE pulse
//   o_checksum      only when BRAM_LOADER_CHECKSUM_EN is defined: mod-2^DWIDTH sum of the words written this run
//   bus             bram_stream_loader_if.slave: byte stream in, BRAM write port out
module bram_stream_loader #(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 12,
    parameter int MEM_SIZE      = 4096,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    output logic               o_idle,
    output logic               o_write,
    output logic               o_done,
`ifdef BRAM_LOADER_CHECKSUM_EN
    output logic [DWIDTH-1:0]  o_checksum,
`endif
    bram_stream_loader_if.slave bus
);
    // Wide enough to hold MEM_SIZE itself (a clamped count of 4096 needs 13 bits).
    localparam int NW = $clog2(MEM_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     num_q, num_d;
    logic [NW-1:0]     word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [DWIDTH-1:0] pack_q, pack_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DWIDTH-1:0] wdat_q, wdat_d;
`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [DWIDTH-1:0] sum_q, sum_d;
`endif

    logic s_ready_c;
    logic accept;

    assign s_ready_c = (state_q == S_RUN) && (word_cnt_q < num_q);
    assign accept    = bus.s_valid && s_ready_c;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        addr_d     = addr_q;
        wr_d       = 1'b0;
        wdat_d     = '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        // Accumulate while the strobe is on the port; the final word lands in time for DONE.
        if (wr_q) begin
            sum_d = sum_q + wdat_q;
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    state_d    = S_RUN;
                    num_d      = (i_num_cnt > CNT_BIT'(MEM_SIZE)) ? NW'(MEM_SIZE) : NW'(i_num_cnt);
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    pack_d     = '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end

            S_RUN: begin
                if (accept) begin
                    // Shift left so the first byte of the word ends up in the MSBs.
                    pack_d     = {pack_q[DWIDTH-IN_DATA_WIDTH-1:0], bus.s_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_d       = 1'b1;
                        wdat_d     = {pack_q[DWIDTH-IN_DATA_WIDTH-1:0], bus.s_data};
                        addr_d     = word_cnt_q[AWIDTH-1:0];
                        word_cnt_d = word_cnt_q + NW'(1);
                    end
                end
                // The count first matches in the cycle carrying the final strobe (or at once when num is 0),
                // so leaving here never cuts off a pending write.
                if (word_cnt_q == num_q) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            pack_q     <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdat_q     <= '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdat_q     <= wdat_d;
`ifdef BRAM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign o_idle      = (state_q == S_IDLE);
    assign o_write     = (state_q == S_RUN);
    assign o_done      = (state_q == S_DONE);
    assign bus.s_ready = s_ready_c;
    assign bus.addr    = addr_q;
    assign bus.ce      = wr_q;
    assign bus.we      = wr_q;
    assign bus.d       = wdat_q;
`ifdef BRAM_LOADER_CHECKSUM_EN
    assign o_checksum  = sum_q;
`endif
endmodule
